// File: rtl/mgmt_register_bank.sv
// Byte-wide management register bank: gated read-only status words plus writable control bytes.
// Optional read timeout is built when MGMT_RD_TIMEOUT_EN is defined.
module mgmt_register_bank #(
    parameter int unsigned ADDR_WIDTH     = 16,
    parameter int unsigned NUM_RO_WORDS   = 4,
    parameter int unsigned RO_WORD_BYTES  = 8,
    parameter int unsigned NUM_RW         = 16,
    parameter int unsigned RW_BASE        = 16'h0100,
    parameter int unsigned TIMEOUT_CYCLES = 1023
) (
    input  logic                                    clk,
    input  logic                                    rst_n,
    input  logic                                    rd_en,
    input  logic [ADDR_WIDTH-1:0]                   rd_addr,
    output logic                                    rd_valid,
    output logic [7:0]                              rd_data,
    output logic                                    rd_err,
    input  logic                                    wr_en,
    input  logic [ADDR_WIDTH-1:0]                   wr_addr,
    input  logic [7:0]                              wr_data,
    input  logic [NUM_RO_WORDS-1:0]                 ro_valid,
    input  logic [NUM_RO_WORDS*RO_WORD_BYTES*8-1:0] ro_data,
    output logic [NUM_RW*8-1:0]                     rw_regs,
    output logic [NUM_RW-1:0]                       rw_wr_strobe
);

    localparam int unsigned WORD_W   = RO_WORD_BYTES * 8;
    localparam int unsigned RO_BYTES = NUM_RO_WORDS * RO_WORD_BYTES;
    localparam int unsigned WIDX_W   = (NUM_RO_WORDS > 1) ? $clog2(NUM_RO_WORDS) : 1;
    localparam int unsigned BIDX_W   = (RO_WORD_BYTES > 1) ? $clog2(RO_WORD_BYTES) : 1;
    localparam int unsigned RIDX_W   = (NUM_RW > 1) ? $clog2(NUM_RW) : 1;

    if (RW_BASE < RO_BYTES) begin : g_bad_rw_base
        $error("mgmt_register_bank: RW_BASE overlaps the read-only region");
    end
    if (TIMEOUT_CYCLES == 0) begin : g_bad_timeout
        $error("mgmt_register_bank: TIMEOUT_CYCLES must be nonzero");
    end

    typedef enum logic {
        ST_IDLE,
        ST_WAIT
    } state_t;

    state_t                  state;
    logic [NUM_RW-1:0][7:0]  rw_q;
    logic [WIDX_W-1:0]       wait_word;
    logic [BIDX_W-1:0]       wait_byte;
    logic                    post_wait;

`ifdef MGMT_RD_TIMEOUT_EN
    localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TO_W-1:0]         to_cnt;
`endif

    // Status words split into bytes, MSB-first within each word
    logic [7:0] ro_bytes [NUM_RO_WORDS][RO_WORD_BYTES];

    always_comb begin
        for (int w = 0; w < int'(NUM_RO_WORDS); w++) begin
            for (int j = 0; j < int'(RO_WORD_BYTES); j++) begin
                ro_bytes[w][j] = ro_data[w*WORD_W + WORD_W - 8*(j+1) +: 8];
            end
        end
    end

    // Read address decode
    logic [ADDR_WIDTH-1:0] rd_off;
    logic                  rd_hit_ro;
    logic                  rd_hit_rw;
    logic [WIDX_W-1:0]     rd_word;
    logic [BIDX_W-1:0]     rd_byte;
    logic [RIDX_W-1:0]     rd_ridx;

    always_comb begin
        rd_off    = rd_addr - ADDR_WIDTH'(RW_BASE);
        rd_hit_ro = rd_addr < ADDR_WIDTH'(RO_BYTES);
        rd_hit_rw = (rd_addr >= ADDR_WIDTH'(RW_BASE)) && (rd_off < ADDR_WIDTH'(NUM_RW));
        rd_word   = WIDX_W'(rd_addr / ADDR_WIDTH'(RO_WORD_BYTES));
        rd_byte   = BIDX_W'(rd_addr % ADDR_WIDTH'(RO_WORD_BYTES));
        rd_ridx   = RIDX_W'(rd_off);
    end

    // Write address decode
    logic [ADDR_WIDTH-1:0] wr_off;
    logic                  wr_hit_rw;
    logic [RIDX_W-1:0]     wr_ridx;

    always_comb begin
        wr_off    = wr_addr - ADDR_WIDTH'(RW_BASE);
        wr_hit_rw = (wr_addr >= ADDR_WIDTH'(RW_BASE)) && (wr_off < ADDR_WIDTH'(NUM_RW));
        wr_ridx   = RIDX_W'(wr_off);
    end

    // Control byte writes, independent of the read FSM
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rw_q         <= '0;
            rw_wr_strobe <= '0;
        end else begin
            rw_wr_strobe <= '0;
            if (wr_en && wr_hit_rw) begin
                rw_q[wr_ridx]         <= wr_data;
                rw_wr_strobe[wr_ridx] <= 1'b1;
            end
        end
    end

    assign rw_regs = rw_q;

    // Read FSM; post_wait masks rd_en in the rd_valid cycle of a read that waited
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            rd_valid  <= 1'b0;
            rd_data   <= 8'h00;
            rd_err    <= 1'b0;
            wait_word <= '0;
            wait_byte <= '0;
            post_wait <= 1'b0;
`ifdef MGMT_RD_TIMEOUT_EN
            to_cnt    <= '0;
`endif
        end else begin
            rd_valid  <= 1'b0;
            rd_err    <= 1'b0;
            post_wait <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (rd_en && !post_wait) begin
                        if (rd_hit_rw) begin
                            rd_valid <= 1'b1;
                            rd_data  <= rw_q[rd_ridx];
                        end else if (rd_hit_ro) begin
                            if (ro_valid[rd_word]) begin
                                rd_valid <= 1'b1;
                                rd_data  <= ro_bytes[rd_word][rd_byte];
                            end else begin
                                state     <= ST_WAIT;
                                wait_word <= rd_word;
                                wait_byte <= rd_byte;
`ifdef MGMT_RD_TIMEOUT_EN
                                to_cnt    <= '0;
`endif
                            end
                        end else begin
                            rd_valid <= 1'b1;
                            rd_err   <= 1'b1;
                            rd_data  <= 8'h00;
                        end
                    end
                end
                ST_WAIT: begin
                    if (ro_valid[wait_word]) begin
                        rd_valid  <= 1'b1;
                        rd_data   <= ro_bytes[wait_word][wait_byte];
                        post_wait <= 1'b1;
                        state     <= ST_IDLE;
                    end
`ifdef MGMT_RD_TIMEOUT_EN
                    else if (to_cnt == TO_W'(TIMEOUT_CYCLES)) begin
                        rd_valid  <= 1'b1;
                        rd_err    <= 1'b1;
                        rd_data   <= 8'h00;
                        post_wait <= 1'b1;
                        state     <= ST_IDLE;
                    end else begin
                        to_cnt <= to_cnt + TO_W'(1);
                    end
`endif
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mgmt_register_bank.sv
// Bench for mgmt_register_bank: vector table of reads/writes, scoreboard of expected read completions.
module tb_mgmt_register_bank;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         rd_en;
    logic [15:0]  rd_addr;
    logic         rd_valid;
    logic [7:0]   rd_data;
    logic         rd_err;
    logic         wr_en;
    logic [15:0]  wr_addr;
    logic [7:0]   wr_data;
    logic [3:0]   ro_valid;
    logic [255:0] ro_data;
    logic [127:0] rw_regs;
    logic [15:0]  rw_wr_strobe;

    mgmt_register_bank #(.TIMEOUT_CYCLES(15)) dut (
        .clk(clk), .rst_n(rst_n),
        .rd_en(rd_en), .rd_addr(rd_addr),
        .rd_valid(rd_valid), .rd_data(rd_data), .rd_err(rd_err),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .ro_valid(ro_valid), .ro_data(ro_data),
        .rw_regs(rw_regs), .rw_wr_strobe(rw_wr_strobe)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int vcount  = 0;

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [7:0] data;
        logic       err;
        int         at;
    } exp_rd_t;

    exp_rd_t sb[$];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic expect_rd(input logic [7:0] d, input logic e, input int at);
        exp_rd_t x;
        x.data = d;
        x.err  = e;
        x.at   = at;
        sb.push_back(x);
    endtask

    // Scoreboard: each rd_valid pops one expectation, including the cycle it must arrive in
    always @(negedge clk) begin
        if (rd_valid === 1'b1) begin
            vcount++;
            n_tests++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL rd_unexpected: got data=%0h err=%0b at cycle %0d, expected no rd_valid",
                         rd_data, rd_err, cyc);
            end else begin
                exp_rd_t x;
                x = sb.pop_front();
                if (rd_data !== x.data || rd_err !== x.err || cyc != x.at) begin
                    n_fail++;
                    $display("FAIL rd_result: got data=%0h err=%0b cycle=%0d, expected data=%0h err=%0b cycle=%0d",
                             rd_data, rd_err, cyc, x.data, x.err, x.at);
                end
            end
        end else if (rd_err !== 1'b0) begin
            n_tests++;
            n_fail++;
            $display("FAIL rd_err_idle: got %0b expected 0", rd_err);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [15:0] addr;
        logic [7:0]  data;
        logic        err;
    } rd_vec_t;

    typedef struct {
        logic [15:0] addr;
        logic [7:0]  data;
        logic [15:0] strobe;
    } wr_vec_t;

    rd_vec_t      rv[10];
    wr_vec_t      wv[5];
    logic [127:0] rw_exp;
    int           v0;

    initial begin
        rv[0] = '{16'h0008, 8'h01, 1'b0};
        rv[1] = '{16'h000F, 8'hEF, 1'b0};
        rv[2] = '{16'h0000, 8'h11, 1'b0};
        rv[3] = '{16'h0007, 8'h88, 1'b0};
        rv[4] = '{16'h0015, 8'hFE, 1'b0};
        rv[5] = '{16'h001F, 8'h78, 1'b0};
        rv[6] = '{16'h0080, 8'h00, 1'b1};
        rv[7] = '{16'h0020, 8'h00, 1'b1};
        rv[8] = '{16'h0110, 8'h00, 1'b1};
        rv[9] = '{16'h0100, 8'h00, 1'b0};

        wv[0] = '{16'h0102, 8'hA5, 16'h0004};
        wv[1] = '{16'h0005, 8'h77, 16'h0000};
        wv[2] = '{16'h010F, 8'h5A, 16'h8000};
        wv[3] = '{16'h0110, 8'h99, 16'h0000};
        wv[4] = '{16'h00FF, 8'h11, 16'h0000};

        rst_n    = 1'b0;
        rd_en    = 1'b0;
        rd_addr  = '0;
        wr_en    = 1'b0;
        wr_addr  = '0;
        wr_data  = '0;
        ro_valid = 4'hF;
        ro_data  = {64'h0F1E2D3C4B5A6978, 64'hDEADBEEFCAFEF00D,
                    64'h0123456789ABCDEF, 64'h1122334455667788};
        rw_exp   = '0;
        repeat (3) tick();
        check("reset_rd_valid", 128'(rd_valid), 128'(0));
        check("reset_rd_data", 128'(rd_data), 128'(0));
        check("reset_rd_err", 128'(rd_err), 128'(0));
        check("reset_rw_regs", rw_regs, 128'(0));
        check("reset_strobe", 128'(rw_wr_strobe), 128'(0));
        rst_n = 1'b1;
        tick();

        // Back-to-back reads, one per cycle
        for (int i = 0; i < 10; i++) begin
            rd_en   = 1'b1;
            rd_addr = rv[i].addr;
            expect_rd(rv[i].data, rv[i].err, cyc + 1);
            tick();
        end
        rd_en = 1'b0;
        tick();

        // Writes: control bytes update with a one-cycle strobe, others ignored
        for (int i = 0; i < 5; i++) begin
            wr_en   = 1'b1;
            wr_addr = wv[i].addr;
            wr_data = wv[i].data;
            if (wv[i].strobe != 16'h0)
                for (int k = 0; k < 16; k++)
                    if (wv[i].strobe[k]) rw_exp[k*8 +: 8] = wv[i].data;
            tick();
            wr_en = 1'b0;
            check("wr_strobe", 128'(rw_wr_strobe), 128'(wv[i].strobe));
            check("wr_regs", rw_regs, rw_exp);
            tick();
            check("wr_strobe_clear", 128'(rw_wr_strobe), 128'(0));
        end

        rd_en   = 1'b1;
        rd_addr = 16'h0102;
        expect_rd(8'hA5, 1'b0, cyc + 1);
        tick();

        // Same-cycle read and write of one control byte returns the old value
        rd_addr = 16'h0103;
        wr_en   = 1'b1;
        wr_addr = 16'h0103;
        wr_data = 8'h3C;
        expect_rd(8'h00, 1'b0, cyc + 1);
        tick();
        wr_en = 1'b0;
        check("rw_strobe_b3", 128'(rw_wr_strobe), 128'(16'h0008));
        expect_rd(8'h3C, 1'b0, cyc + 1);
        tick();
        rd_en = 1'b0;
        repeat (2) tick();

        // Waiting read on word 0 while other words are valid; extra rd_en in WAIT is dropped
        ro_valid = 4'hE;
        rd_en    = 1'b1;
        rd_addr  = 16'h0003;
        tick();
        rd_addr  = 16'h0008;
        tick();
        rd_en    = 1'b0;
        repeat (3) tick();
        ro_valid = 4'hF;
        expect_rd(8'h44, 1'b0, cyc + 1);
        repeat (4) tick();
        check("wait_sb_drained", 128'(sb.size()), 128'(0));

        // Status word never becomes valid
        ro_valid = 4'h0;
        rd_en    = 1'b1;
        rd_addr  = 16'h0000;
        v0       = vcount;
`ifdef MGMT_RD_TIMEOUT_EN
        expect_rd(8'h00, 1'b1, cyc + 17);
`endif
        tick();
        rd_en = 1'b0;
        repeat (1000) tick();
`ifdef MGMT_RD_TIMEOUT_EN
        check("timeout_valid_count", 128'(vcount - v0), 128'(1));
`else
        check("no_timeout_valid_count", 128'(vcount - v0), 128'(0));
`endif

        // Reset while waiting aborts the read
        rd_en   = 1'b1;
        rd_addr = 16'h0000;
        tick();
        rd_en = 1'b0;
        repeat (3) tick();
        rst_n = 1'b0;
        tick();
        check("wreset_rd_valid", 128'(rd_valid), 128'(0));
        check("wreset_rd_data", 128'(rd_data), 128'(0));
        check("wreset_rd_err", 128'(rd_err), 128'(0));
        check("wreset_rw_regs", rw_regs, 128'(0));
        check("wreset_strobe", 128'(rw_wr_strobe), 128'(0));
        rst_n    = 1'b1;
        ro_valid = 4'hF;
        repeat (5) tick();
        rd_en   = 1'b1;
        rd_addr = 16'h0008;
        expect_rd(8'h01, 1'b0, cyc + 1);
        tick();
        rd_en = 1'b0;
        repeat (3) tick();
        check("final_sb_drained", 128'(sb.size()), 128'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
